// File: rtl/neuron_input_buffer.sv
// neuron_input_buffer: gathers N (x, w) operand pairs from a valid/ready
// producer, pulses neuron_start, then presents one pair per neuron_load
// until the neuron reports neuron_ready, which reopens the buffer.
// Optional build macro: INBUF_OVERRUN_FLAG_EN adds a sticky 'overrun' output
// flagging neuron_load/neuron_ready strobes that arrive in the wrong state.
module neuron_input_buffer #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_w,
    output logic          neuron_start,
    input  logic          neuron_load,
    input  logic          neuron_ready,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] w_out,
    output logic          busy,
`ifdef INBUF_OVERRUN_FLAG_EN
    output logic          overrun,
`endif
    output logic [7:0]    fill_count
);

    // Storage is rounded up to a power of two so the pointer slice indexes it
    // exactly; entries at N and above are never written or read.
    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [7:0] LAST = 8'(N - 1);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        DRAIN     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [7:0]      r_wrPtr;
    logic [7:0]      r_rdPtr;
    logic [7:0]      r_fillCount;
    logic [2*DW-1:0] r_mem [0:DEPTH-1];

    logic            w_accept;
    logic            w_load;
    logic            w_frameEnd;
    logic [AW-1:0]   w_wrIdx;
    logic [AW-1:0]   w_rdIdx;

    assign w_wrIdx    = r_wrPtr[AW-1:0];
    assign w_rdIdx    = r_rdPtr[AW-1:0];
    assign w_accept   = in_valid && in_ready;
    assign w_load     = neuron_load && (r_state == DRAIN);
    assign w_frameEnd = neuron_ready && (r_state == WAIT_DONE);

    // in_ready is held low while reset is asserted, even before the state settles.
    assign in_ready     = rst && (r_state == FILL);
    assign neuron_start = (r_state == START);
    assign busy         = (r_state != FILL);
    assign fill_count   = r_fillCount;

    // Next-state decode: a frame fills, fires one start cycle, drains, then waits.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && (r_wrPtr == LAST)) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_nextState = DRAIN;
            end
            DRAIN: begin
                if (w_load && (r_rdPtr == LAST)) begin
                    w_nextState = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (w_frameEnd) begin
                    w_nextState = FILL;
                end
            end
            default: begin
                w_nextState = FILL;
            end
        endcase
    end

    // Present the pair under the read pointer only while draining, zero otherwise.
    always_comb begin
        x_out = '0;
        w_out = '0;
        if (r_state == DRAIN) begin
            x_out = r_mem[w_rdIdx][2*DW-1:DW];
            w_out = r_mem[w_rdIdx][DW-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pointers and occupancy: fill on accept, drain on load, clear at frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fillCount <= '0;
        end else if (w_frameEnd) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fillCount <= '0;
        end else if (w_accept) begin
            r_wrPtr     <= r_wrPtr + 8'd1;
            r_fillCount <= r_fillCount + 8'd1;
        end else if (w_load) begin
            r_rdPtr     <= r_rdPtr + 8'd1;
            r_fillCount <= r_fillCount - 8'd1;
        end
    end

    // Operand storage is deliberately left unreset; stale data is never presented.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_wrIdx] <= {in_x, in_w};
        end
    end

`ifdef INBUF_OVERRUN_FLAG_EN
    // Sticky flag for neuron strobes arriving in a state that cannot use them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if ((neuron_load && (r_state != DRAIN)) ||
                     (neuron_ready && (r_state != WAIT_DONE))) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
